rx_uart: RTL and testbench

RX_UART -- requirements
Module: rx_uart

---
 rtl/rx_uart.sv | 194 +++++++++++++++++++
 tb/tb_rx_uart.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_uart.sv
// 8N1 UART receiver, 16x oversampled: o_data/o_rx_done_tick update 1 cycle after the STOP timeout.
// No backpressure: a frame that completes while the previous word is unread overwrites o_data.
module rx_uart #(
    parameter int NB_STATE        = 3,
    parameter int NB_COUNT        = 4,
    parameter int NB_DATA_COUNT   = 3,
    parameter int NB_DATA         = 8,
    parameter int N_TICKS_TO_STOP = 30,
    parameter int BAUD_DIV        = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic               o_rx_done_tick,
    output logic [NB_DATA-1:0] o_data
);

    localparam int NB_STOP = (N_TICKS_TO_STOP > 1) ? $clog2(N_TICKS_TO_STOP) : 1;

    localparam logic [NB_COUNT-1:0]      TICK_LAST   = '1;
    localparam logic [NB_COUNT-1:0]      TICK_MID    = {1'b0, {(NB_COUNT-1){1'b1}}};
    localparam logic [NB_DATA_COUNT-1:0] BIT_LAST    = NB_DATA_COUNT'(NB_DATA - 1);
    localparam logic [NB_STOP-1:0]       STOP_SAMPLE = NB_STOP'((2**NB_COUNT) - 1);
    localparam logic [NB_STOP-1:0]       STOP_LAST   = NB_STOP'(N_TICKS_TO_STOP - 1);

    typedef enum logic [NB_STATE-1:0] {
        S_IDLE  = 0,
        S_START = 1,
        S_DATA  = 2,
        S_STOP  = 3
    } state_t;

    logic                     r_rx_meta;
    logic                     r_rx_sync;
    logic                     w_rx_s;
    logic                     w_tick;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NB_COUNT-1:0]      r_tick_cnt;
    logic [NB_COUNT-1:0]      w_tick_cnt_nxt;
    logic [NB_DATA_COUNT-1:0] r_bit_cnt;
    logic [NB_DATA_COUNT-1:0] w_bit_cnt_nxt;
    logic [NB_STOP-1:0]       r_stop_cnt;
    logic [NB_STOP-1:0]       w_stop_cnt_nxt;
    logic [NB_DATA-1:0]       r_shift;
    logic [NB_DATA-1:0]       w_shift_nxt;
    logic                     r_stop_bit;
    logic                     w_stop_bit_nxt;
    logic                     w_stop_val;
    logic [NB_DATA-1:0]       r_data;
    logic [NB_DATA-1:0]       w_data_nxt;
    logic                     r_done;
    logic                     w_done_nxt;

    // Reset to 1 so the idle line is never mistaken for a start bit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx_s = r_rx_sync;

    generate
        if (BAUD_DIV > 1) begin : g_baud
            localparam int NB_BAUD = $clog2(BAUD_DIV);
            localparam logic [NB_BAUD-1:0] BAUD_LAST = NB_BAUD'(BAUD_DIV - 1);
            logic [NB_BAUD-1:0] r_baud_cnt;

            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    r_baud_cnt <= '0;
                end else if (r_baud_cnt == BAUD_LAST) begin
                    r_baud_cnt <= '0;
                end else begin
                    r_baud_cnt <= r_baud_cnt + 1'b1;
                end
            end

            assign w_tick = (r_baud_cnt == BAUD_LAST);
        end else begin : g_no_baud
            assign w_tick = 1'b1;
        end
    endgenerate

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_shift    <= '0;
            r_stop_bit <= 1'b0;
            r_data     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_stop_bit <= w_stop_bit_nxt;
            r_data     <= w_data_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // The stop sample may land on the very tick that ends STOP, so use it directly then.
    assign w_stop_val = (r_stop_cnt == STOP_SAMPLE) ? w_rx_s : r_stop_bit;

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_cnt_nxt = r_tick_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_shift_nxt    = r_shift;
        w_stop_bit_nxt = r_stop_bit;
        w_data_nxt     = r_data;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_tick && !w_rx_s) begin
                    w_state_nxt    = S_START;
                    w_tick_cnt_nxt = '0;
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_shift_nxt    = {w_rx_s, r_shift[NB_DATA-1:1]};
                        w_tick_cnt_nxt = '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_cnt_nxt  = '0;
                            w_stop_cnt_nxt = '0;
                            w_state_nxt    = S_STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == STOP_SAMPLE) begin
                        w_stop_bit_nxt = w_rx_s;
                    end
                    if (r_stop_cnt == STOP_LAST) begin
                        w_stop_cnt_nxt = '0;
                        w_state_nxt    = S_IDLE;
                        if (w_stop_val) begin
                            w_data_nxt = r_shift;
                            w_done_nxt = 1'b1;
                        end
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_tick_cnt_nxt = '0;
                w_bit_cnt_nxt  = '0;
                w_stop_cnt_nxt = '0;
            end
        endcase
    end

    assign o_rx_done_tick = r_done;
    assign o_data         = r_data;

endmodule

// File: tb/tb_rx_uart.sv
// Bench for rx_uart: directed frames plus random frames scored against a last-valid-word model.
`timescale 1ns/1ps
module tb_rx_uart;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx1 = 1'b1;
    logic       rx4 = 1'b1;
    logic       done1, done4;
    logic [7:0] data1, data4;

    always #5 clk = ~clk;

    rx_uart #(.BAUD_DIV(1)) dut1 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_rx          (rx1),
        .o_rx_done_tick(done1),
        .o_data        (data1)
    );

    rx_uart #(.BAUD_DIV(4)) dut4 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_rx          (rx4),
        .o_rx_done_tick(done4),
        .o_data        (data4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] cap1[$];
    logic [7:0] cap4[$];
    int         wide1 = 0;
    int         wide4 = 0;
    logic       prev1 = 1'b0;
    logic       prev4 = 1'b0;
    logic [7:0] last_exp1 = 8'h00;

    always @(negedge clk) begin
        if (done1) begin
            cap1.push_back(data1);
            if (prev1) wide1++;
        end
        if (done4) begin
            cap4.push_back(data4);
            if (prev4) wide4++;
        end
        prev1 = done1;
        prev4 = done4;
    end

    task automatic drive_line(input bit use4, input logic v, input int cycles);
        if (use4) rx4 = v;
        else      rx1 = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Model of the line: start, LSB-first data, stop. A good stop bit makes d the expected word.
    task automatic send_frame(input bit use4, input logic [7:0] d, input logic stop, input int cpb);
        drive_line(use4, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_line(use4, d[i], cpb);
        drive_line(use4, stop, cpb);
        if (!use4 && stop) last_exp1 = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_exp1 = 8'h00;
        cap1.delete();
        cap4.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx1 = 1'b1;
        rx4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (data1 !== 8'h00) $display("FAIL reset_data1 got %h want 00", data1); else n_pass++;
        n_checks++;
        if (done1 !== 1'b0) $display("FAIL reset_done1 got %b want 0", done1); else n_pass++;
        n_checks++;
        if (data4 !== 8'h00) $display("FAIL reset_data4 got %h want 00", data4); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_idle_line();
        drive_line(1'b0, 1'b1, 1000);
        n_checks++;
        if (cap1.size() != 0) $display("FAIL idle_pulses got %0d want 0", cap1.size()); else n_pass++;
        n_checks++;
        if (data1 !== 8'h00) $display("FAIL idle_data got %h want 00", data1); else n_pass++;
    endtask

    task automatic test_framing_error();
        apply_reset();
        drive_line(1'b0, 1'b1, 5);
        send_frame(1'b0, 8'hBD, 1'b0, 16);
        drive_line(1'b0, 1'b1, 48);
        n_checks++;
        if (cap1.size() != 0) $display("FAIL ferr_pulses got %0d want 0", cap1.size()); else n_pass++;
        n_checks++;
        if (data1 !== 8'h00) $display("FAIL ferr_data got %h want 00", data1); else n_pass++;
    endtask

    task automatic test_known_frame();
        logic [7:0] got;
        apply_reset();
        drive_line(1'b0, 1'b1, 5);
        send_frame(1'b0, 8'hBD, 1'b1, 16);
        drive_line(1'b0, 1'b1, 48);
        got = (cap1.size() > 0) ? cap1[0] : 8'hxx;
        n_checks++;
        if (cap1.size() != 1) $display("FAIL bd_pulses got %0d want 1", cap1.size()); else n_pass++;
        n_checks++;
        if (got !== 8'hBD) $display("FAIL bd_pulse_data got %h want bd", got); else n_pass++;
        n_checks++;
        if (data1 !== 8'hBD) $display("FAIL bd_data got %h want bd", data1); else n_pass++;
    endtask

    task automatic test_glitch();
        cap1.delete();
        drive_line(1'b0, 1'b0, 4);
        drive_line(1'b0, 1'b1, 40);
        n_checks++;
        if (cap1.size() != 0) $display("FAIL glitch_pulses got %0d want 0", cap1.size()); else n_pass++;
        n_checks++;
        if (data1 !== last_exp1) $display("FAIL glitch_data got %h want %h", data1, last_exp1); else n_pass++;
        send_frame(1'b0, 8'h5A, 1'b1, 16);
        drive_line(1'b0, 1'b1, 48);
        n_checks++;
        if (cap1.size() != 1) $display("FAIL post_glitch_pulses got %0d want 1", cap1.size()); else n_pass++;
        n_checks++;
        if (data1 !== 8'h5A) $display("FAIL post_glitch_data got %h want 5a", data1); else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 24; f++) begin
            logic [7:0] d;
            logic       stop;
            int         exp_cnt;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            exp_cnt = stop ? 1 : 0;
            cap1.delete();
            send_frame(1'b0, d, stop, 16);
            drive_line(1'b0, 1'b1, $urandom_range(24, 60));
            n_checks++;
            if (cap1.size() != exp_cnt)
                $display("FAIL rand_pulses[%0d] got %0d want %0d", f, cap1.size(), exp_cnt);
            else n_pass++;
            n_checks++;
            if (data1 !== last_exp1)
                $display("FAIL rand_data[%0d] got %h want %h", f, data1, last_exp1);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        cap1.delete();
        send_frame(1'b0, 8'h3C, 1'b1, 16);
        drive_line(1'b0, 1'b1, 40);
        n_checks++;
        if (data1 !== 8'h3C) $display("FAIL pre_abort_data got %h want 3c", data1); else n_pass++;
        d = 8'hA5;
        drive_line(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_line(1'b0, d[i], 16);
        drive_line(1'b0, d[4], 8);
        rst = 1'b1;
        #1;
        n_checks++;
        if (data1 !== 8'h00) $display("FAIL abort_data got %h want 00", data1); else n_pass++;
        n_checks++;
        if (done1 !== 1'b0) $display("FAIL abort_done got %b want 0", done1); else n_pass++;
        rx1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        last_exp1 = 8'h00;
        cap1.delete();
        cap4.delete();
        drive_line(1'b0, 1'b1, 200);
        n_checks++;
        if (cap1.size() != 0) $display("FAIL after_abort_pulses got %0d want 0", cap1.size()); else n_pass++;
        send_frame(1'b0, 8'hC3, 1'b1, 16);
        drive_line(1'b0, 1'b1, 48);
        n_checks++;
        if (cap1.size() != 1) $display("FAIL c3_pulses got %0d want 1", cap1.size()); else n_pass++;
        n_checks++;
        if (data1 !== 8'hC3) $display("FAIL c3_data got %h want c3", data1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got0, got1;
        cap4.delete();
        drive_line(1'b1, 1'b1, 20);
        send_frame(1'b1, 8'h00, 1'b1, 64);
        send_frame(1'b1, 8'hFF, 1'b1, 64);
        drive_line(1'b1, 1'b1, 300);
        got0 = (cap4.size() > 0) ? cap4[0] : 8'hxx;
        got1 = (cap4.size() > 1) ? cap4[1] : 8'hxx;
        n_checks++;
        if (cap4.size() != 2) $display("FAIL b2b_pulses got %0d want 2", cap4.size()); else n_pass++;
        n_checks++;
        if (got0 !== 8'h00) $display("FAIL b2b_first got %h want 00", got0); else n_pass++;
        n_checks++;
        if (got1 !== 8'hFF) $display("FAIL b2b_second got %h want ff", got1); else n_pass++;
        n_checks++;
        if (data4 !== 8'hFF) $display("FAIL b2b_data got %h want ff", data4); else n_pass++;
    endtask

    task automatic test_pulse_width();
        n_checks++;
        if (wide1 != 0) $display("FAIL width_dut1 got %0d long pulses want 0", wide1); else n_pass++;
        n_checks++;
        if (wide4 != 0) $display("FAIL width_dut4 got %0d long pulses want 0", wide4); else n_pass++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_idle_line();
        test_framing_error();
        test_known_frame();
        test_glitch();
        test_random_frames();
        test_reset_midframe();
        test_back_to_back();
        test_pulse_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
